// File: rtl/v1_pulse_gen.sv
`default_nettype none
// ============================================================================
// Module      : v1_pulse_gen
// Description : Synthetic detector-pulse source feeding the trapezoidal
//               filter input. Each accepted request produces a linear rise
//               over 2^RISE_SHIFT cycles up to the requested amplitude,
//               followed by an exponential decay x -= x >>> DECAY_SHIFT.
//               Every sample is offset by BASELINE and saturated to the
//               signed SIZE_FILTER_DATA range.
// Options     : PULSE_GEN_PILEUP_EN - when defined, requests are also
//               accepted during DECAY and stack on the residual tail.
// Revision    : 1.0 - initial release
// ============================================================================
module v1_pulse_gen #(
  parameter int SIZE_FILTER_DATA = 16,
  parameter int RISE_SHIFT       = 1,
  parameter int DECAY_SHIFT      = 4,
  parameter int BASELINE         = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        trig_valid,
  input  logic [SIZE_FILTER_DATA-2:0] trig_amp,
  output logic                        trig_ready,
  output logic [SIZE_FILTER_DATA-1:0] output_data,
  output logic                        busy,
  output logic [15:0]                 pulse_count
);

  // Accumulator is unsigned and one bit narrower than the sample word.
  localparam int c_ACC_W = SIZE_FILTER_DATA - 1;
  // Rise counter must be able to hold 2^RISE_SHIFT itself.
  localparam int c_RCNT_W = RISE_SHIFT + 1;
  // Headroom width for sums before saturation.
  localparam int c_XW = SIZE_FILTER_DATA + 8;

  localparam logic [c_RCNT_W-1:0]     c_RISE_LEN = c_RCNT_W'(1 << RISE_SHIFT);
  localparam logic [c_XW-1:0]         c_ACC_MAX  = c_XW'((1 << c_ACC_W) - 1);
  localparam logic signed [c_XW-1:0]  c_OUT_MAX  = c_XW'((1 << (SIZE_FILTER_DATA - 1)) - 1);
  localparam logic signed [c_XW-1:0]  c_OUT_MIN  = c_XW'(-(1 << (SIZE_FILTER_DATA - 1)));
  localparam logic signed [c_XW-1:0]  c_BASE     = c_XW'(BASELINE);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RISE  = 2'd1,
    ST_DECAY = 2'd2
  } state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [c_ACC_W-1:0]          r_acc;
  logic [c_ACC_W-1:0]          r_base;
  logic [c_ACC_W-1:0]          r_amp;
  logic [c_ACC_W-1:0]          r_step;
  logic [c_RCNT_W-1:0]         r_rcnt;
  logic [15:0]                 r_count;
  logic [SIZE_FILTER_DATA-1:0] r_out;

  logic [c_ACC_W-1:0]          w_acc_nxt;
  logic [c_ACC_W-1:0]          w_base_nxt;
  logic [c_ACC_W-1:0]          w_amp_nxt;
  logic [c_ACC_W-1:0]          w_step_nxt;
  logic [c_RCNT_W-1:0]         w_rcnt_nxt;
  logic [c_RCNT_W-1:0]         w_rcnt_inc;
  logic [c_ACC_W-1:0]          w_decay;
  logic [c_XW-1:0]             w_rise_sum;
  logic [c_XW-1:0]             w_full_sum;
  logic                        w_ready;
  logic                        w_accept;

  // Clamp an unsigned sum to the accumulator range so acc never wraps.
  function automatic logic [c_ACC_W-1:0] sat_acc(input logic [c_XW-1:0] v);
    if (v > c_ACC_MAX) sat_acc = c_ACC_MAX[c_ACC_W-1:0];
    else               sat_acc = v[c_ACC_W-1:0];
  endfunction

  // Add the baseline and clamp to the signed sample range.
  function automatic logic [SIZE_FILTER_DATA-1:0] sat_out(input logic [c_ACC_W-1:0] a);
    logic signed [c_XW-1:0] s;
    s = c_BASE + $signed(c_XW'(a));
    if (s > c_OUT_MAX)      sat_out = c_OUT_MAX[SIZE_FILTER_DATA-1:0];
    else if (s < c_OUT_MIN) sat_out = c_OUT_MIN[SIZE_FILTER_DATA-1:0];
    else                    sat_out = s[SIZE_FILTER_DATA-1:0];
  endfunction

  // Next-state, handshake and accumulator update for the pulse shape.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_base_nxt  = r_base;
    w_amp_nxt   = r_amp;
    w_step_nxt  = r_step;
    w_rcnt_nxt  = r_rcnt;
    w_ready     = 1'b0;
    w_decay     = r_acc >> DECAY_SHIFT;
    w_rcnt_inc  = r_rcnt + 1'b1;
    w_rise_sum  = c_XW'(r_base) + c_XW'(r_step) * c_XW'(w_rcnt_inc);
    w_full_sum  = c_XW'(r_base) + c_XW'(r_amp);

    case (r_state)
      ST_IDLE: begin
        w_ready   = 1'b1;
        w_acc_nxt = '0;
      end
      ST_RISE: begin
        w_rcnt_nxt = w_rcnt_inc;
        if (w_rcnt_inc == c_RISE_LEN) begin
          // Last rise step lands exactly on base+amp, hiding the step truncation.
          w_acc_nxt   = sat_acc(w_full_sum);
          w_state_nxt = ST_DECAY;
        end else begin
          w_acc_nxt = sat_acc(w_rise_sum);
        end
      end
      ST_DECAY: begin
`ifdef PULSE_GEN_PILEUP_EN
        w_ready = 1'b1;
`else
        w_ready = 1'b0;
`endif
        if (w_decay == '0) begin
          w_acc_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else begin
          w_acc_nxt = r_acc - w_decay;
        end
      end
      default: begin
        w_acc_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_accept = trig_valid && w_ready;
    if (w_accept) begin
      // A tail that is terminating this edge counts as zero; the request wins.
      if ((r_state == ST_DECAY) && (w_decay != '0)) w_base_nxt = r_acc;
      else                                          w_base_nxt = '0;
      w_acc_nxt   = w_base_nxt;
      w_amp_nxt   = trig_amp;
      w_step_nxt  = trig_amp >> RISE_SHIFT;
      w_rcnt_nxt  = '0;
      w_state_nxt = ST_RISE;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Datapath registers; the output follows the accumulator value of the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc   <= '0;
      r_base  <= '0;
      r_amp   <= '0;
      r_step  <= '0;
      r_rcnt  <= '0;
      r_count <= '0;
      r_out   <= sat_out('0);
    end else begin
      r_acc  <= w_acc_nxt;
      r_base <= w_base_nxt;
      r_amp  <= w_amp_nxt;
      r_step <= w_step_nxt;
      r_rcnt <= w_rcnt_nxt;
      r_out  <= sat_out(w_acc_nxt);
      if (w_accept) r_count <= r_count + 16'd1;
    end
  end

  assign trig_ready  = w_ready;
  assign output_data = r_out;
  assign busy        = (r_state != ST_IDLE);
  assign pulse_count = r_count;

endmodule
`default_nettype wire
